ad9866_gain_ctrl: RTL and testbench



---
 rtl/ad9866_gain_ctrl.sv | 156 +++++++++++++++
 tb/tb_ad9866_gain_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad9866_gain_ctrl.sv
// AD9866 RX-gain request scheduler: one SPI gain write at a time, with redundant-write suppression, holdoff and ACK timeout.
// Define AD9866_GAIN_AGC_EN to add overload-driven auto-attenuation (atten is tied to 0 otherwise).
module ad9866_gain_ctrl #(
  parameter logic [5:0] RESET_GAIN    = 6'd20,
  parameter int         INIT_WAIT_CYC = 4096,
  parameter int         ACK_TIMEOUT   = 1024,
  parameter int         HOLDOFF_CYC   = 64,
  parameter int         OVF_WIN       = 4096,
  parameter int         OVF_THRESH    = 8,
  parameter int         OVF_STEP      = 3,
  parameter int         RECOVER_WINS  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] host_gain,
  input  logic       host_gain_valid,
  input  logic       sen_n,
  input  logic       adc_ovf,
  output logic [5:0] gain,
  output logic       extrqst,
  output logic       busy,
  output logic       timeout_err,
  output logic [5:0] atten
);

  localparam int CNT_MAX = (INIT_WAIT_CYC > ACK_TIMEOUT)
                         ? ((INIT_WAIT_CYC > HOLDOFF_CYC) ? INIT_WAIT_CYC : HOLDOFF_CYC)
                         : ((ACK_TIMEOUT > HOLDOFF_CYC) ? ACK_TIMEOUT : HOLDOFF_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_WAIT_INIT, S_IDLE, S_REQ, S_XFER, S_HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_target, r_gain, r_last_written, w_eff, w_atten;
  logic             r_lw_valid, r_sen_prev, r_timeout_err;
  logic             w_pending, w_done, w_timeout;

  always_comb begin
    w_eff     = (r_target > w_atten) ? (r_target - w_atten) : 6'd0;
    w_pending = !r_lw_valid || (w_eff != r_last_written);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_WAIT_INIT: if (r_cnt == CNT_W'(INIT_WAIT_CYC - 1)) w_state_nxt = S_IDLE;
      S_IDLE:      if (w_pending) w_state_nxt = S_REQ;
      S_REQ: begin
        if (!sen_n) begin
          w_state_nxt = S_XFER;
        end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          w_state_nxt = S_HOLD;
          w_timeout   = 1'b1;
        end
      end
      // Completion is the writer releasing sen_n after the transfer.
      S_XFER: begin
        if (sen_n && !r_sen_prev) begin
          w_state_nxt = S_HOLD;
          w_done      = 1'b1;
        end
      end
      S_HOLD:      if (r_cnt == CNT_W'(HOLDOFF_CYC - 1)) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_WAIT_INIT;
      r_cnt          <= '0;
      r_target       <= RESET_GAIN;
      r_gain         <= RESET_GAIN;
      r_last_written <= 6'd0;
      r_lw_valid     <= 1'b0;
      r_sen_prev     <= 1'b1;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= (w_state_nxt != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      r_sen_prev <= sen_n;
      if (host_gain_valid) r_target <= host_gain;
      if (r_state == S_IDLE && w_state_nxt == S_REQ) r_gain <= w_eff;
      if (w_done) begin
        r_last_written <= r_gain;
        r_lw_valid     <= 1'b1;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

`ifdef AD9866_GAIN_AGC_EN
  localparam int WIN_W = $clog2(OVF_WIN + 1);
  localparam int OC_W  = $clog2(OVF_THRESH + 1);
  localparam int CL_W  = $clog2(RECOVER_WINS + 1);

  logic [WIN_W-1:0] r_win_cnt;
  logic [OC_W-1:0]  r_ovf_cnt, w_ovf_tot;
  logic [CL_W-1:0]  r_clean_cnt;
  logic [5:0]       r_atten;
  logic [6:0]       w_att_sum;
  logic             w_win_end;

  // The overflow seen on the window's last cycle still counts toward that window.
  always_comb begin
    w_ovf_tot = (adc_ovf && r_ovf_cnt != OC_W'(OVF_THRESH)) ? r_ovf_cnt + 1'b1 : r_ovf_cnt;
    w_win_end = (r_win_cnt == WIN_W'(OVF_WIN - 1));
    w_att_sum = {1'b0, r_atten} + 7'(OVF_STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_cnt   <= '0;
      r_ovf_cnt   <= '0;
      r_clean_cnt <= '0;
      r_atten     <= 6'd0;
    end else if (w_win_end) begin
      r_win_cnt <= '0;
      r_ovf_cnt <= '0;
      if (w_ovf_tot == OC_W'(OVF_THRESH)) begin
        r_atten     <= (w_att_sum > 7'd63) ? 6'd63 : w_att_sum[5:0];
        r_clean_cnt <= '0;
      end else if (w_ovf_tot == '0) begin
        if (r_clean_cnt == CL_W'(RECOVER_WINS - 1)) begin
          r_clean_cnt <= '0;
          if (r_atten != 6'd0) r_atten <= r_atten - 1'b1;
        end else begin
          r_clean_cnt <= r_clean_cnt + 1'b1;
        end
      end else begin
        r_clean_cnt <= '0;
      end
    end else begin
      r_win_cnt <= r_win_cnt + 1'b1;
      r_ovf_cnt <= w_ovf_tot;
    end
  end

  assign w_atten = r_atten;
`else
  localparam int agc_cfg_unused = OVF_WIN + OVF_THRESH + OVF_STEP + RECOVER_WINS;
  logic w_ovf_unused;
  assign w_ovf_unused = adc_ovf;
  assign w_atten      = 6'd0;
`endif

  assign gain        = r_gain;
  assign extrqst     = (r_state == S_REQ);
  assign busy        = (r_state == S_REQ) || (r_state == S_XFER) || (r_state == S_HOLD);
  assign timeout_err = r_timeout_err;
  assign atten       = w_atten;

endmodule

// File: tb/tb_ad9866_gain_ctrl.sv
// Directed bench for ad9866_gain_ctrl with a behavioural SPI-writer model driving sen_n.
module tb_ad9866_gain_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] host_gain = 6'd0;
  logic       host_gain_valid = 1'b0;
  logic       sen_n;
  logic       adc_ovf = 1'b0;
  logic [5:0] gain, atten;
  logic       extrqst, busy, timeout_err;

  logic       wr_en = 1'b0, wr_low = 1'b0, man_low = 1'b0;
  logic [5:0] wr_log [0:31];
  int         n_wr = 0;
  int         n_chk = 0, n_err = 0;
  int         cyc = 0;

  assign sen_n = ~(wr_low | man_low);

  ad9866_gain_ctrl #(
    .RESET_GAIN(6'd20), .INIT_WAIT_CYC(16), .ACK_TIMEOUT(8), .HOLDOFF_CYC(8),
    .OVF_WIN(32), .OVF_THRESH(4), .OVF_STEP(3), .RECOVER_WINS(16)
  ) dut (
    .clk(clk), .reset(reset), .host_gain(host_gain), .host_gain_valid(host_gain_valid),
    .sen_n(sen_n), .adc_ovf(adc_ovf), .gain(gain), .extrqst(extrqst), .busy(busy),
    .timeout_err(timeout_err), .atten(atten)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(3);
    reset = 1'b0;
  endtask

  task automatic strobe(input logic [5:0] v);
    @(negedge clk);
    host_gain       = v;
    host_gain_valid = 1'b1;
    @(negedge clk);
    host_gain_valid = 1'b0;
  endtask

  task automatic wait_busy(input string tag, input logic lvl, input int lim);
    for (int i = 0; i < lim && busy !== lvl; i++) @(negedge clk);
    check(tag, busy, lvl);
  endtask

  task automatic wait_cyc(input string tag, input int target);
    for (int i = 0; i < 2000 && cyc < target; i++) @(negedge clk);
    check(tag, cyc, target);
  endtask

  // Writer model: answers a request after two cycles and holds sen_n low for 33 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_en && extrqst && !reset) begin
        run(2);
        check("wr_req_held", extrqst, 1);
        if (n_wr < 32) wr_log[n_wr] = gain;
        n_wr++;
        wr_low = 1'b1;
        @(negedge clk);
        check("wr_req_drop", extrqst, 0);
        run(32);
        wr_low = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int found30;

    // Stalled writer: timeout and retry.
    run(2);
    @(negedge clk);
    reset = 1'b0;
    check("rst_extrqst", extrqst, 0);
    check("rst_gain", gain, 20);
    check("rst_busy", busy, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_atten", atten, 0);
    run(16);
    check("init_no_req", extrqst, 0);
    check("init_not_busy", busy, 0);
    run(1);
    check("req_c17", extrqst, 1);
    check("req_gain", gain, 20);
    check("req_busy", busy, 1);
    run(7);
    check("req_c24", extrqst, 1);
    check("tmo_c24", timeout_err, 0);
    run(1);
    check("tmo_drop", extrqst, 0);
    check("tmo_sticky", timeout_err, 1);
    check("hold_busy", busy, 1);
    run(8);
    check("hold_no_req", extrqst, 0);
    check("hold_idle", busy, 0);
    run(1);
    check("retry_req", extrqst, 1);

    // Writer model present: initial write, host write, redundant strobe.
    wr_en = 1'b1;
    do_reset();
    base = n_wr;
    run(100);
    check("init_wr_cnt", n_wr - base, 1);
    check("init_wr_val", wr_log[base], 20);
    strobe(6'd45);
    wait_busy("w45_busy", 1'b1, 10);
    wait_busy("w45_done", 1'b0, 100);
    check("w45_cnt", n_wr - base, 2);
    check("w45_val", wr_log[base + 1], 45);
    check("w45_gain", gain, 45);
    check("w45_no_tmo", timeout_err, 0);
    strobe(6'd45);
    run(60);
    check("dup_no_wr", n_wr - base, 2);
    check("dup_idle", busy, 0);

    // Updates during a transfer: current write unchanged, only latest value follows.
    base = n_wr;
    strobe(6'd50);
    for (int i = 0; i < 20 && !wr_low; i++) @(negedge clk);
    check("xfer_seen", wr_low, 1);
    strobe(6'd30);
    strobe(6'd40);
    check("xfer_gain", gain, 50);
    check("xfer_busy", busy, 1);
    run(150);
    check("mid_cnt", n_wr - base, 2);
    check("mid_first", wr_log[base], 50);
    check("mid_second", wr_log[base + 1], 40);
    found30 = 0;
    for (int i = 0; i < n_wr && i < 32; i++) if (wr_log[i] == 6'd30) found30++;
    check("never_30", found30, 0);
    check("mid_gain", gain, 40);

    // sen_n activity while IDLE is ignored.
    wr_en   = 1'b0;
    base    = n_wr;
    man_low = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_sen_req", extrqst, 0);
      check("idle_sen_busy", busy, 0);
    end
    man_low = 1'b0;
    run(5);
    check("idle_after_req", extrqst, 0);
    check("idle_after_busy", busy, 0);
    check("idle_after_gain", gain, 40);

    // Reset while in REQ.
    strobe(6'd10);
    @(negedge clk);
    check("pre_rst_req", extrqst, 1);
    check("pre_rst_gain", gain, 10);
    #2 reset = 1'b1;
    #1;
    check("arst_extrqst", extrqst, 0);
    check("arst_gain", gain, 20);
    check("arst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    run(16);
    check("rinit_no_req", extrqst, 0);
    run(1);
    check("rinit_req", extrqst, 1);
    check("rinit_gain", gain, 20);

`ifdef AD9866_GAIN_AGC_EN
    // Overload trips attenuation; 16 clean windows release one step.
    wr_en = 1'b1;
    do_reset();
    strobe(6'd40);
    run(150);
    check("agc_base_gain", gain, 40);
    check("agc_base_att", atten, 0);
    for (int i = 0; i < 64 && (cyc % 32) != 0; i++) @(negedge clk);
    adc_ovf = 1'b1;
    run(5);
    adc_ovf = 1'b0;
    base = ((cyc + 31) / 32) * 32;
    wait_cyc("agc_win_end", base);
    check("agc_trip_att", atten, 3);
    run(100);
    check("agc_wr37", wr_log[n_wr - 1], 37);
    check("agc_gain37", gain, 37);
    wait_cyc("agc_15_clean", base + 32 * 15);
    check("agc_hold_att", atten, 3);
    wait_cyc("agc_16_clean", base + 32 * 16);
    check("agc_rel_att", atten, 2);
    run(100);
    check("agc_wr38", wr_log[n_wr - 1], 38);
    check("agc_gain38", gain, 38);
`else
    // Without auto-attenuation, overload has no effect.
    wr_en = 1'b1;
    do_reset();
    run(100);
    base    = n_wr;
    adc_ovf = 1'b1;
    run(100);
    adc_ovf = 1'b0;
    check("noagc_att", atten, 0);
    check("noagc_no_wr", n_wr - base, 0);
    check("noagc_gain", gain, 20);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
